// File: rtl/power_domain_sequencer.sv
// Power-up/power-down sequencer for one switchable domain: orders switch enable,
// isolation, retention strobes and domain reset, with a sticky switch-timeout fault.
module power_domain_sequencer #(
  parameter int SW_TIMEOUT = 64,
  parameter int RET_CYCLES = 4,
  parameter int ISO_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pwr_req_sync,
  input  logic switch_ack,
  output logic pd_switch_en,
  output logic pd_iso_en,
  output logic pd_ret_save,
  output logic pd_ret_restore,
  output logic pd_reset,
  output logic pwr_ack,
  output logic busy,
  output logic fault
);

  typedef enum logic [2:0] {
    S_OFF, S_SW_ON, S_RESTORE, S_ON, S_ISO_SET, S_SAVE, S_SW_OFF, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYCLES - 1);

  // Output vector order: switch_en, iso_en, pd_reset, ret_save, ret_restore, pwr_ack, busy
  function automatic logic [6:0] decode(input state_t s);
    logic [6:0] v;
    case (s)
      S_OFF:     v = 7'b0110000;
      S_SW_ON:   v = 7'b1110001;
      S_RESTORE: v = 7'b1100101;
      S_ON:      v = 7'b1000010;
      S_ISO_SET: v = 7'b1100001;
      S_SAVE:    v = 7'b1101001;
      S_SW_OFF:  v = 7'b0110001;
      S_FAULT:   v = 7'b0110000;
      default:   v = 7'b0110000;
    endcase
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [6:0]       out_q, out_d;

  // Next-state, dwell counter, sticky fault and next output decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:     if (pwr_req_sync) state_d = S_SW_ON; else state_d = S_OFF;
      S_SW_ON: begin
        if (switch_ack)            state_d = S_RESTORE;
        else if (cnt_q == SW_LAST) state_d = S_FAULT;
        else                       state_d = S_SW_ON;
      end
      S_RESTORE: if (cnt_q == RET_LAST) state_d = S_ON; else state_d = S_RESTORE;
      S_ON:      if (!pwr_req_sync) state_d = S_ISO_SET; else state_d = S_ON;
      S_ISO_SET: if (cnt_q == ISO_LAST) state_d = S_SAVE; else state_d = S_ISO_SET;
      S_SAVE:    if (cnt_q == RET_LAST) state_d = S_SW_OFF; else state_d = S_SAVE;
      S_SW_OFF: begin
        if (!switch_ack)           state_d = S_OFF;
        else if (cnt_q == SW_LAST) state_d = S_FAULT;
        else                       state_d = S_SW_OFF;
      end
      S_FAULT:   if (!pwr_req_sync) state_d = S_OFF; else state_d = S_FAULT;
      default:   state_d = S_OFF;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);

    fault_d = fault_q | (state_d == S_FAULT);
    out_d   = decode(state_d);
  end

  // FSM state, counter, fault and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      out_q   <= 7'b0110000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      out_q   <= out_d;
    end
  end

  assign {pd_switch_en, pd_iso_en, pd_reset, pd_ret_save, pd_ret_restore, pwr_ack, busy} = out_q;
  assign fault = fault_q;

endmodule
